cc_branch_unit: RTL and testbench

CC_BRANCH_UNIT -- requirements
Module: cc_branch_unit

---
 rtl/cc_branch_unit.sv | 127 ++++++++++++
 tb/tb_cc_branch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cc_branch_unit.sv
// Per-context condition-code tracker with branch resolution.
// Also counts taken branches, saturating at the counter maximum.
module cc_branch_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_CTX = 4,
    parameter int unsigned CTX_W   = 2,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                   clka,
    input  logic                   reset_in,
    input  logic                   we_reg_in,
    input  logic [CTX_W-1:0]       wr_ctx_in,
    input  logic [DATA_W-1:0]      wr_data_in,
    input  logic                   flags_src_in,
    input  logic                   n_alu_in,
    input  logic                   z_alu_in,
    input  logic                   p_alu_in,
    input  logic                   br_in,
    input  logic [CTX_W-1:0]       br_ctx_in,
    input  logic                   n_dec_in,
    input  logic                   z_dec_in,
    input  logic                   p_dec_in,
    input  logic                   cnt_clr_in,
    output logic                   pc_ctl_0_out,
    output logic [CTX_W-1:0]       br_ctx_out,
    output logic [3*NUM_CTX-1:0]   state_out,
    output logic [CNT_W-1:0]       taken_cnt_out
);

    localparam int unsigned CC_W = 3;
    localparam int unsigned ST_W = CC_W * NUM_CTX;

    localparam logic [CC_W-1:0] CC_IDLE = 3'b000;
    localparam logic [CC_W-1:0] CC_N    = 3'b100;
    localparam logic [CC_W-1:0] CC_Z    = 3'b010;
    localparam logic [CC_W-1:0] CC_P    = 3'b001;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ST_W-1:0]  state_q;
    logic [CC_W-1:0]  new_cc_c;
    logic             has_upd_c;
    logic             wr_ok_c;
    logic             br_ok_c;
    logic [CC_W-1:0]  stored_c;
    logic [CC_W-1:0]  cc_eff_c;
    logic             taken_c;

    // New flags from either the write-back value or the explicit ALU flags.
    always_comb begin
        new_cc_c  = CC_IDLE;
        has_upd_c = 1'b0;
        if (!flags_src_in) begin
            has_upd_c = 1'b1;
            if (wr_data_in[DATA_W-1]) begin
                new_cc_c = CC_N;
            end else if (wr_data_in == '0) begin
                new_cc_c = CC_Z;
            end else begin
                new_cc_c = CC_P;
            end
        end else if (n_alu_in) begin
            has_upd_c = 1'b1;
            new_cc_c  = CC_N;
        end else if (z_alu_in) begin
            has_upd_c = 1'b1;
            new_cc_c  = CC_Z;
        end else if (p_alu_in) begin
            has_upd_c = 1'b1;
            new_cc_c  = CC_P;
        end
    end

    assign wr_ok_c = we_reg_in && has_upd_c && (32'(wr_ctx_in) < NUM_CTX);
    assign br_ok_c = 32'(br_ctx_in) < NUM_CTX;

    // Stored state of the branch context; out-of-range contexts read as IDLE.
    always_comb begin
        stored_c = CC_IDLE;
        for (int k = 0; k < int'(NUM_CTX); k++) begin
            if (br_ctx_in == CTX_W'(k)) begin
                stored_c = state_q[CC_W*k +: CC_W];
            end
        end
    end

    always_comb begin
        cc_eff_c = stored_c;
        if ((BYPASS != 0) && wr_ok_c && (wr_ctx_in == br_ctx_in)) begin
            cc_eff_c = new_cc_c;
        end
    end

    assign taken_c = br_in && br_ok_c &&
                     (({n_dec_in, z_dec_in, p_dec_in} & cc_eff_c) != CC_IDLE);

    always_ff @(posedge clka) begin
        if (reset_in) begin
            state_q       <= '0;
            pc_ctl_0_out  <= 1'b0;
            br_ctx_out    <= '0;
            taken_cnt_out <= '0;
        end else begin
            if (wr_ok_c) begin
                for (int k = 0; k < int'(NUM_CTX); k++) begin
                    if (wr_ctx_in == CTX_W'(k)) begin
                        state_q[CC_W*k +: CC_W] <= new_cc_c;
                    end
                end
            end
            pc_ctl_0_out <= taken_c;
            if (taken_c) begin
                br_ctx_out <= br_ctx_in;
            end
            // Clear has priority over the taken increment.
            if (cnt_clr_in) begin
                taken_cnt_out <= '0;
            end else if (taken_c && (taken_cnt_out != CNT_MAX)) begin
                taken_cnt_out <= taken_cnt_out + CNT_W'(1);
            end
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed bench for cc_branch_unit; a second instance with forwarding disabled
// shares all inputs to contrast same-cycle write visibility.
module tb_cc_branch_unit;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NUM_CTX = 4;
    localparam int unsigned CTX_W   = 2;
    localparam int unsigned CNT_W   = 8;

    logic              clka = 1'b0;
    logic              reset_in = 1'b1;
    logic              we_reg_in = 1'b0;
    logic [CTX_W-1:0]  wr_ctx_in = '0;
    logic [DATA_W-1:0] wr_data_in = '0;
    logic              flags_src_in = 1'b0;
    logic              n_alu_in = 1'b0;
    logic              z_alu_in = 1'b0;
    logic              p_alu_in = 1'b0;
    logic              br_in = 1'b0;
    logic [CTX_W-1:0]  br_ctx_in = '0;
    logic              n_dec_in = 1'b0;
    logic              z_dec_in = 1'b0;
    logic              p_dec_in = 1'b0;
    logic              cnt_clr_in = 1'b0;

    logic                 pc1, pc0;
    logic [CTX_W-1:0]     bctx1, bctx0;
    logic [3*NUM_CTX-1:0] st1, st0;
    logic [CNT_W-1:0]     cnt1, cnt0;

    int total = 0;
    int bad   = 0;

    always #5 clka = ~clka;

    cc_branch_unit #(.DATA_W(DATA_W), .NUM_CTX(NUM_CTX), .CTX_W(CTX_W),
                     .BYPASS(1), .CNT_W(CNT_W)) dut (
        .clka(clka), .reset_in(reset_in), .we_reg_in(we_reg_in),
        .wr_ctx_in(wr_ctx_in), .wr_data_in(wr_data_in),
        .flags_src_in(flags_src_in), .n_alu_in(n_alu_in),
        .z_alu_in(z_alu_in), .p_alu_in(p_alu_in), .br_in(br_in),
        .br_ctx_in(br_ctx_in), .n_dec_in(n_dec_in), .z_dec_in(z_dec_in),
        .p_dec_in(p_dec_in), .cnt_clr_in(cnt_clr_in),
        .pc_ctl_0_out(pc1), .br_ctx_out(bctx1), .state_out(st1),
        .taken_cnt_out(cnt1)
    );

    cc_branch_unit #(.DATA_W(DATA_W), .NUM_CTX(NUM_CTX), .CTX_W(CTX_W),
                     .BYPASS(0), .CNT_W(CNT_W)) dut_nb (
        .clka(clka), .reset_in(reset_in), .we_reg_in(we_reg_in),
        .wr_ctx_in(wr_ctx_in), .wr_data_in(wr_data_in),
        .flags_src_in(flags_src_in), .n_alu_in(n_alu_in),
        .z_alu_in(z_alu_in), .p_alu_in(p_alu_in), .br_in(br_in),
        .br_ctx_in(br_ctx_in), .n_dec_in(n_dec_in), .z_dec_in(z_dec_in),
        .p_dec_in(p_dec_in), .cnt_clr_in(cnt_clr_in),
        .pc_ctl_0_out(pc0), .br_ctx_out(bctx0), .state_out(st0),
        .taken_cnt_out(cnt0)
    );

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic n, input logic z, input logic p);
        n_alu_in = n;
        z_alu_in = z;
        p_alu_in = p;
    endtask

    task automatic mask(input logic n, input logic z, input logic p);
        n_dec_in = n;
        z_dec_in = z;
        p_dec_in = p;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_state", 32'(st1), 32'h000);
        check("rst_pc", 32'(pc1), 32'h0);
        check("rst_bctx", 32'(bctx1), 32'h0);
        check("rst_cnt", 32'(cnt1), 32'h0);
        reset_in = 1'b0;

        // Write strobe low: nothing changes
        flags_src_in = 1'b1;
        wr_ctx_in    = 2'd2;
        wr_data_in   = 16'h1234;
        alu(1, 0, 0); step(); check("gated_n", 32'(st1), 32'h000);
        alu(0, 1, 0); step(); check("gated_z", 32'(st1), 32'h000);
        alu(0, 0, 1); step(); check("gated_p", 32'(st1), 32'h000);

        // Explicit flags into ctx 2 (bits 8:6)
        we_reg_in = 1'b1;
        alu(1, 0, 0); step(); check("exp_n", 32'(st1), 32'h100);
        alu(0, 1, 0); step(); check("exp_z", 32'(st1), 32'h080);
        alu(0, 0, 1); step(); check("exp_p", 32'(st1), 32'h040);
        alu(0, 0, 0); step(); check("exp_none", 32'(st1), 32'h040);
        alu(1, 1, 0); step(); check("exp_prio", 32'(st1), 32'h100);

        // Derived flags into ctx 0
        flags_src_in = 1'b0;
        alu(0, 0, 0);
        wr_ctx_in  = 2'd0;
        wr_data_in = 16'h8000; step(); check("der_n", 32'(st1), 32'h104);
        wr_data_in = 16'h0000; step(); check("der_z", 32'(st1), 32'h102);
        wr_data_in = 16'h0001; step(); check("der_p", 32'(st1), 32'h101);

        // ctx 1 = N, then branch on it
        flags_src_in = 1'b1;
        wr_ctx_in    = 2'd1;
        alu(1, 0, 0); step(); check("ctx1_n", 32'(st1), 32'h121);
        we_reg_in = 1'b0;
        alu(0, 0, 0);
        br_in = 1'b1; br_ctx_in = 2'd1; mask(1, 0, 0);
        step();
        check("br_pc", 32'(pc1), 32'h1);
        check("br_bctx", 32'(bctx1), 32'h1);
        check("br_cnt", 32'(cnt1), 32'h1);
        br_in = 1'b0;
        step();
        check("br_off_pc", 32'(pc1), 32'h0);
        check("br_off_bctx_hold", 32'(bctx1), 32'h1);

        // Same-cycle write P to ctx 1 with branch mask 001
        we_reg_in = 1'b1; wr_ctx_in = 2'd1; alu(0, 0, 1);
        br_in = 1'b1; br_ctx_in = 2'd1; mask(0, 0, 1);
        step();
        check("byp1_pc", 32'(pc1), 32'h1);
        check("byp0_pc", 32'(pc0), 32'h0);
        check("byp_state", 32'(st1), 32'h109);
        check("byp0_state", 32'(st0), 32'h109);

        // Write ctx 3 = Z while branching on ctx 2 (N)
        wr_ctx_in = 2'd3; alu(0, 1, 0);
        br_ctx_in = 2'd2; mask(1, 0, 0);
        step();
        check("ab_pc", 32'(pc1), 32'h1);
        check("ab_bctx", 32'(bctx1), 32'h2);
        check("ab_state", 32'(st1), 32'h509);
        check("ab_cnt1", 32'(cnt1), 32'h3);
        check("ab_cnt0", 32'(cnt0), 32'h2);
        we_reg_in = 1'b0; alu(0, 0, 0);

        // Reset during a would-be taken branch
        reset_in = 1'b1;
        step();
        check("rbr_pc", 32'(pc1), 32'h0);
        check("rbr_bctx", 32'(bctx1), 32'h0);
        check("rbr_cnt", 32'(cnt1), 32'h0);
        check("rbr_state", 32'(st1), 32'h000);
        reset_in = 1'b0;

        // IDLE context never taken
        br_ctx_in = 2'd0; mask(1, 1, 1);
        step(); check("idle_pc", 32'(pc1), 32'h0);
        br_in = 1'b0;

        // ctx 0 = Z, mask 101 not taken, mask 010 taken
        we_reg_in = 1'b1; flags_src_in = 1'b0; wr_ctx_in = 2'd0; wr_data_in = 16'h0000;
        step(); check("z_state", 32'(st1), 32'h002);
        we_reg_in = 1'b0;
        br_in = 1'b1; mask(1, 0, 1);
        step(); check("mis_pc", 32'(pc1), 32'h0);
        mask(0, 1, 0);
        step();
        check("z_pc", 32'(pc1), 32'h1);
        check("z_cnt", 32'(cnt1), 32'h1);

        // Saturation: 260 more taken branches
        for (int i = 0; i < 260; i++) step();
        check("sat_cnt1", 32'(cnt1), 32'hFF);
        check("sat_cnt0", 32'(cnt0), 32'hFF);
        check("sat_pc", 32'(pc1), 32'h1);

        // Clear beats a simultaneous increment
        cnt_clr_in = 1'b1;
        step();
        check("clr_cnt", 32'(cnt1), 32'h0);
        check("clr_pc", 32'(pc1), 32'h1);
        cnt_clr_in = 1'b0;
        step(); check("post_clr_cnt", 32'(cnt1), 32'h1);
        br_in = 1'b0;
        step();
        check("end_pc", 32'(pc1), 32'h0);
        check("end_cnt", 32'(cnt1), 32'h1);

        // Final reset clears everything
        reset_in = 1'b1;
        step();
        check("frst_state", 32'(st1), 32'h000);
        check("frst_cnt", 32'(cnt1), 32'h0);
        check("frst_bctx", 32'(bctx1), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
